// File: rtl/fp_cmp_pkg.sv
// Shared types, cond-field bit positions and helpers for the shared FP comparator scheduler.
package fp_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int COND_LT = 2;
  localparam int COND_EQ = 1;
  localparam int COND_UN = 0;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  // c.cond.s predicate; cond[3] (signal-on-NaN) deliberately has no effect.
  function automatic logic pred(input logic lt, input logic eq, input logic un,
                                input logic [3:0] cond);
    return (lt & cond[COND_LT]) | (eq & cond[COND_EQ]) | (un & cond[COND_UN]);
  endfunction

  function automatic logic [31:0] canon_zero(input logic [31:0] x);
    logic [31:0] r;
    if (x == FP_NEG_ZERO) r = FP_POS_ZERO;
    else                  r = x;
    return r;
  endfunction

endpackage

// File: rtl/fp_cmp_scheduler_if.sv
// Request and response channels of fp_cmp_scheduler; req_cc exists only with FP_CMP_FCC_EN.
interface fp_cmp_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][31:0]      req_a;
  logic [NUM_REQ-1:0][31:0]      req_b;
  logic [NUM_REQ-1:0][3:0]       req_cond;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
`ifdef FP_CMP_FCC_EN
  logic [NUM_REQ-1:0][2:0]       req_cc;
`endif
  logic                          resp_valid;
  logic                          resp_ready;
  logic [IDW-1:0]                resp_id;
  logic [TAG_W-1:0]              resp_tag;
  logic                          resp_lt;
  logic                          resp_eq;
  logic                          resp_gt;
  logic                          resp_un;
  logic                          resp_pred;

`ifdef FP_CMP_FCC_EN
  modport master (output req_valid, req_a, req_b, req_cond, req_tag, req_cc, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_tag,
                         resp_lt, resp_eq, resp_gt, resp_un, resp_pred);
  modport slave  (input  req_valid, req_a, req_b, req_cond, req_tag, req_cc, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_tag,
                         resp_lt, resp_eq, resp_gt, resp_un, resp_pred);
`else
  modport master (output req_valid, req_a, req_b, req_cond, req_tag, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_tag,
                         resp_lt, resp_eq, resp_gt, resp_un, resp_pred);
  modport slave  (input  req_valid, req_a, req_b, req_cond, req_tag, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_tag,
                         resp_lt, resp_eq, resp_gt, resp_un, resp_pred);
`endif

endinterface

// File: rtl/fp_comparator.sv
// IEEE-754 single ordered/unordered compare; expects -0 already folded to +0 by the caller.
module fp_comparator (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        lt_o,
  output logic        eq_o,
  output logic        gt_o
);

  logic a_nan_s, b_nan_s, mag_lt_s, mag_eq_s;

  assign a_nan_s  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
  assign b_nan_s  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
  assign mag_lt_s = a_i[30:0] <  b_i[30:0];
  assign mag_eq_s = a_i[30:0] == b_i[30:0];

  // Sign-magnitude ordering; any NaN leaves all three relations low.
  always_comb begin
    lt_o = 1'b0;
    eq_o = 1'b0;
    gt_o = 1'b0;
    if (a_nan_s || b_nan_s) begin
      eq_o = 1'b0;
    end else if (a_i[31] != b_i[31]) begin
      lt_o = a_i[31];
      gt_o = b_i[31];
    end else if (mag_eq_s) begin
      eq_o = 1'b1;
    end else if (a_i[31] == 1'b0) begin
      lt_o = mag_lt_s;
      gt_o = ~mag_lt_s;
    end else begin
      lt_o = ~mag_lt_s;
      gt_o = mag_lt_s;
    end
  end

endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin grant: first requester at or above ptr_i (wrapping) wins; one-hot grant plus index.
module fp_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o
);

  int   cand_s;
  logic found_s;

  // Rotating priority scan starting at the pointer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (int'(ptr_i) + k) % NUM_REQ;
      if (!found_s && req_i[cand_s[IDW-1:0]]) begin
        found_s                  = 1'b1;
        grant_o[cand_s[IDW-1:0]] = 1'b1;
        idx_o                    = cand_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_scheduler.sv
// Round-robin sharing of one FP comparator between NUM_REQ requesters (accept -> latch -> respond).
// Define FP_CMP_FCC_EN to add the req_cc inputs and the 8-bit fcc register.
import fp_cmp_pkg::*;

module fp_cmp_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef FP_CMP_FCC_EN
  output logic [7:0]        fcc,
`endif
  fp_cmp_scheduler_if.slave bus
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, grant_idx_s, id_q;
  logic [NUM_REQ-1:0] grant_s, ready_s;
  logic               grant_en_s, accept_s, hs_s;
  logic [31:0]        a_q, b_q;
  logic [3:0]         cond_q;
  logic [TAG_W-1:0]   tag_q;
  logic               cmp_lt_s, cmp_eq_s, cmp_gt_s, cmp_un_s, cmp_pred_s;
  logic               resp_valid_q, resp_valid_d;
  logic [IDW-1:0]     resp_id_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic               resp_lt_q, resp_eq_q, resp_gt_q, resp_un_q, resp_pred_q;

  fp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s),
    .idx_o   (grant_idx_s)
  );

  fp_comparator u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .lt_o (cmp_lt_s),
    .eq_o (cmp_eq_s),
    .gt_o (cmp_gt_s)
  );

  assign cmp_un_s   = ~(cmp_lt_s | cmp_eq_s | cmp_gt_s);
  assign cmp_pred_s = pred(cmp_lt_s, cmp_eq_s, cmp_un_s, cond_q);
  assign hs_s       = resp_valid_q & bus.resp_ready;
  // Grants are suppressed while reset is asserted so no request is accepted then.
  assign ready_s    = grant_s & {NUM_REQ{grant_en_s & reset_n}};
  assign accept_s   = |ready_s;
  assign rr_ptr_d   = (grant_idx_s == IDW'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDW'(1);

  // Next state and grant window.
  always_comb begin
    state_d    = state_q;
    grant_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        grant_en_s = 1'b1;
        if (|grant_s) state_d = LATCH;
        else          state_d = IDLE;
      end
      LATCH: state_d = RESP;
      RESP: begin
        if (hs_s) begin
          grant_en_s = 1'b1;
          state_d    = (|grant_s) ? LATCH : IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    if (state_q == LATCH) resp_valid_d = 1'b1;
    else if (hs_s)        resp_valid_d = 1'b0;
    else                  resp_valid_d = resp_valid_q;
  end

  // State, pointer and operand capture on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      cond_q   <= 4'h0;
      tag_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        rr_ptr_q <= rr_ptr_d;
        a_q      <= canon_zero(bus.req_a[grant_idx_s]);
        b_q      <= canon_zero(bus.req_b[grant_idx_s]);
        cond_q   <= bus.req_cond[grant_idx_s];
        tag_q    <= bus.req_tag[grant_idx_s];
        id_q     <= grant_idx_s;
      end else begin
        rr_ptr_q <= rr_ptr_q;
      end
    end
  end

  // Response registers load in LATCH and hold through backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_tag_q   <= '0;
      resp_lt_q    <= 1'b0;
      resp_eq_q    <= 1'b0;
      resp_gt_q    <= 1'b0;
      resp_un_q    <= 1'b0;
      resp_pred_q  <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      if (state_q == LATCH) begin
        resp_id_q   <= id_q;
        resp_tag_q  <= tag_q;
        resp_lt_q   <= cmp_lt_s;
        resp_eq_q   <= cmp_eq_s;
        resp_gt_q   <= cmp_gt_s;
        resp_un_q   <= cmp_un_s;
        resp_pred_q <= cmp_pred_s;
      end else begin
        resp_id_q <= resp_id_q;
      end
    end
  end

`ifdef FP_CMP_FCC_EN
  logic [2:0] cc_q;
  logic [7:0] fcc_q;

  // FCC bit selected at accept takes the predicate as the response is produced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cc_q  <= 3'd0;
      fcc_q <= 8'h00;
    end else begin
      if (accept_s) cc_q <= bus.req_cc[grant_idx_s];
      else          cc_q <= cc_q;
      if (state_q == LATCH) fcc_q[cc_q] <= cmp_pred_s;
      else                  fcc_q <= fcc_q;
    end
  end

  assign fcc = fcc_q;
`endif

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_lt    = resp_lt_q;
  assign bus.resp_eq    = resp_eq_q;
  assign bus.resp_gt    = resp_gt_q;
  assign bus.resp_un    = resp_un_q;
  assign bus.resp_pred  = resp_pred_q;

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// Directed bench for fp_cmp_scheduler: latency, round-robin order, NaN/zero handling, backpressure, reset, FCC.
module tb_fp_cmp_scheduler;

  logic clock = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clock = ~clock;

  fp_cmp_scheduler_if #(.NUM_REQ(2), .TAG_W(4)) bus ();

`ifdef FP_CMP_FCC_EN
  logic [7:0] fcc;
`endif

  fp_cmp_scheduler #(.NUM_REQ(2), .TAG_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
`ifdef FP_CMP_FCC_EN
    .fcc     (fcc),
`endif
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] rel();
    return {bus.resp_lt, bus.resp_eq, bus.resp_gt, bus.resp_un, bus.resp_pred};
  endfunction

  task automatic drive(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] cond, input logic [3:0] tag, input logic [2:0] cc);
    bus.req_valid[i] = v;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_cond[i]  = cond;
    bus.req_tag[i]   = tag;
`ifdef FP_CMP_FCC_EN
    bus.req_cc[i]    = cc;
`else
    if (cc != 3'd0) bus.req_tag[i] = tag;
`endif
  endtask

  // Single request on requester i from IDLE; returns in the first RESP cycle.
  task automatic one_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cond, input logic [3:0] tag, input logic [2:0] cc);
    drive(i, 1'b1, a, b, cond, tag, cc);
    #1;
    chk("grant", 32'(bus.req_ready), 32'(2'b01 << i));
    tick();
    bus.req_valid[i] = 1'b0;
    chk("latch_no_valid", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_tag", 32'(bus.resp_tag), 32'(tag));
    chk("resp_id", 32'(bus.resp_id), 32'(i));
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cond   = '0;
    bus.req_tag    = '0;
`ifdef FP_CMP_FCC_EN
    bus.req_cc     = '0;
`endif
    bus.resp_ready = 1'b1;
    repeat (3) tick();

    // Reset state: no grant even with a valid request
    bus.req_valid[0] = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rel", 32'(rel()), 32'd0);
    chk("rst_tag", 32'(bus.resp_tag), 32'd0);
`ifdef FP_CMP_FCC_EN
    chk("rst_fcc", 32'(fcc), 32'h00);
`endif
    bus.req_valid[0] = 1'b0;
    reset_n = 1'b1;
    tick();

    // 1.0 < 2.0
    one_req(0, 32'h3F80_0000, 32'h4000_0000, 4'b0100, 4'h3, 3'd0);
    chk("t1_rel", 32'(rel()), 32'(5'b10001));
    tick();
    chk("t1_idle", 32'(bus.resp_valid), 32'd0);

    // NaN operand
    one_req(0, 32'h7FC0_0000, 32'h3F80_0000, 4'b0001, 4'h4, 3'd0);
    chk("t3_un", 32'(rel()), 32'(5'b00011));
    tick();
    one_req(0, 32'h7FC0_0000, 32'h3F80_0000, 4'b0110, 4'h4, 3'd0);
    chk("t3_nopred", 32'(rel()), 32'(5'b00010));
    tick();

    // -0 == +0
    one_req(0, 32'h8000_0000, 32'h0000_0000, 4'b0010, 4'h5, 3'd0);
    chk("t4_zero", 32'(rel()), 32'(5'b01001));
    tick();

    // cond[3] ignored; negative ordering -1 > -2
    one_req(1, 32'h3F80_0000, 32'h4000_0000, 4'b1100, 4'h6, 3'd0);
    chk("t_cond3", 32'(rel()), 32'(5'b10001));
    tick();
    one_req(0, 32'hBF80_0000, 32'hC000_0000, 4'b0111, 4'h7, 3'd0);
    chk("t_neg", 32'(rel()), 32'(5'b00100));
    tick();

    // Round-robin with both requesters continuously valid
    reset_pulse();
    drive(0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 4'b0100, 4'h1, 3'd0);
    drive(1, 1'b1, 32'h4000_0000, 32'h3F80_0000, 4'b0100, 4'h2, 3'd0);
    #1;
    for (int r = 0; r < 4; r++) begin
      chk("t2_grant", 32'(bus.req_ready), 32'(2'b01 << (r % 2)));
      tick();
      chk("t2_latch", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("t2_valid", 32'(bus.resp_valid), 32'd1);
      chk("t2_id", 32'(bus.resp_id), 32'(r % 2));
      chk("t2_tag", 32'(bus.resp_tag), 32'((r % 2) + 1));
      chk("t2_rel", 32'(rel()), (r % 2 == 0) ? 32'(5'b10001) : 32'(5'b00100));
    end
    bus.req_valid = 2'b00;
    tick();
    chk("t2_idle", 32'(bus.resp_valid), 32'd0);

    // Backpressure: response held, no grant while stalled
    bus.resp_ready = 1'b0;
    drive(1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 4'b0100, 4'h5, 3'd0);
    #1;
    chk("t5_grant1", 32'(bus.req_ready), 32'(2'b10));
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    drive(0, 1'b1, 32'h7FC0_0000, 32'h3F80_0000, 4'b0001, 4'h6, 3'd0);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("t5_hold_tag", 32'(bus.resp_tag), 32'h5);
      chk("t5_hold_rel", 32'(rel()), 32'(5'b10001));
      chk("t5_no_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("t5_release_grant", 32'(bus.req_ready), 32'(2'b01));
    tick();
    chk("t5_one_hs", 32'(bus.resp_valid), 32'd0);
    bus.req_valid[1] = 1'b1;
`ifdef FP_CMP_FCC_EN
    chk("t5_fcc_pre", 32'(fcc), 32'h01);
`endif
    // Reset during LATCH drops the in-flight request
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef FP_CMP_FCC_EN
    chk("t5_rst_fcc", 32'(fcc), 32'h00);
`endif
    reset_n = 1'b1;
    #1;
    chk("t5_rr_zero", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t5_after_valid", 32'(bus.resp_valid), 32'd1);
    chk("t5_after_tag", 32'(bus.resp_tag), 32'h6);
    chk("t5_after_rel", 32'(rel()), 32'(5'b00011));
    tick();

`ifdef FP_CMP_FCC_EN
    // FCC update at response
    reset_pulse();
    one_req(0, 32'hFF80_0000, 32'h0000_0001, 4'b0100, 4'h7, 3'd5);
    chk("t6_rel", 32'(rel()), 32'(5'b10001));
    chk("t6_fcc_set", 32'(fcc), 32'h20);
    tick();
    one_req(0, 32'h7FC0_0000, 32'h3F80_0000, 4'b0100, 4'h8, 3'd5);
    chk("t6_fcc_clr", 32'(fcc), 32'h00);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
